pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline (IF, ID, EX, MEM, WB). It watches the ID, EX and MEM stage pipeline registers and generates per-stage hold and clear strobes. It covers three hazards:
- load-use data hazards;
- taken branches resolved in EX;
- multi-cycle data-memory accesses.

It also keeps saturating stall and flush statistics for debug display on the Starter Kit.

Parameters:
MEM_LATENCY, 1, cycles a load/store occupies MEM; legal range 1..15. 1 means no memory stall.
CNT_W, 16, width of the stall/flush statistic counters.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  ID source register A index
id_rt  input  5  ID source register B index
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
ex_valid  input  1  EX stage holds a real instruction
ex_rd  input  5  EX destination register index
ex_mem_read  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle
mem_valid  input  1  MEM stage holds a real instruction
mem_access  input  1  MEM instruction is a load or store
stall_if  output  1  hold PC / IF
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register
stall_mem  output  1  hold EX/MEM register
flush_id  output  1  clear IF/ID register (insert bubble)
flush_ex  output  1  clear ID/EX register (insert bubble)
bubble_wb  output  1  clear MEM/WB register (no register write this cycle)
busy  output  1  FSM not in RUN
stall_count  output  CNT_W  saturating count of cycles with stall_if=1
flush_count  output  CNT_W  saturating count of taken-branch flushes

Behaviour:
- FSM states: RUN and MEM_WAIT. A 4-bit down counter wcnt runs alongside.
- Reset, while reset=1: state<=RUN, wcnt<=0, both counters<=0. All stall/flush/bubble outputs are forced 0 and busy=0.
- Definitions:
  - mem_start = state==RUN & mem_valid & mem_access & MEM_LATENCY>1.
  - mem_hold = mem_start | (state==MEM_WAIT & wcnt!=0).
  - load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - br = ex_valid & ex_branch_taken.
- Outputs are combinational. Priority is mem_hold > br > load_use:
  - mem_hold: stall_if, stall_id, stall_ex and stall_mem =1; bubble_wb=1; flush_id=0, flush_ex=0. Any branch or load-use pending in EX/ID is frozen and re-evaluated when released.
  - else br: flush_id=1, flush_ex=1, all stalls 0. A simultaneous load_use is suppressed, because its ID instruction is being killed.
  - else load_use: stall_if=1, stall_id=1, flush_ex=1. All other outputs 0. The hazard clears itself after one cycle, once the load advances to MEM.
  - else: all 0.
- Transitions:
  - RUN -> MEM_WAIT on mem_start, with wcnt<=MEM_LATENCY-2.
  - In MEM_WAIT with wcnt!=0: wcnt<=wcnt-1.
  - MEM_WAIT -> RUN when wcnt==0. Stalls are deasserted in this cycle and the access completes.
  - Net result: an access occupies MEM exactly MEM_LATENCY cycles, with MEM_LATENCY-1 stall cycles.
- Back-to-back accesses: the next access enters MEM the cycle after the return to RUN and triggers a new mem_start. There is no idle gap.
- busy = (state==MEM_WAIT).
- Counters:
  - stall_count increments on every cycle with stall_if=1.
  - flush_count increments on every cycle with br and not mem_hold.
  - Both saturate at all-ones; no wrap.
- Reset mid-MEM_WAIT: the FSM returns to RUN next edge and wcnt is cleared. There is no residual stall after reset falls.
- Register index 0 never causes a load-use stall.

Test Plan:
1. Load-use: EX load ex_rd=5, ID id_rs=5, id_use_rs=1 -> one cycle of stall_if=stall_id=flush_ex=1; next cycle (ex_mem_read=0) all 0; stall_count=1.
2. No false hazard: ex_rd=0 with id_rs=0, or id_use_rt=0 with id_rt match -> all outputs 0.
3. MEM_LATENCY=3, single load in MEM -> stall_if/id/ex/mem and bubble_wb =1 for exactly 2 cycles, busy=1 for 2 cycles, then 0. With MEM_LATENCY=1 -> no stall ever.
4. Simultaneous events:
   - taken branch in EX plus a load-use condition -> flush_id=flush_ex=1, stall_if=0, flush_count=1.
   - taken branch during MEM_WAIT -> no flush until release; the flush fires in the release cycle; flush_count increments once.
5. Back-to-back stores with MEM_LATENCY=4 -> 3 stall cycles, 1 release cycle, then 3 stall cycles; stall_count=6.
6. Reset asserted in the 2nd MEM_WAIT cycle -> outputs 0 immediately; after release, state RUN, counters 0. Separately, force 2^CNT_W+5 stall cycles -> stall_count holds at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Handles load-use, taken-branch and multi-cycle memory hazards.
module pipeline_hazard_ctrl #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_valid,
    input  logic             mem_access,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_wb,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam bit MULTI = (MEM_LATENCY > 1);
    localparam logic [3:0] WINIT =
        MULTI ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t     state, state_nx;
    logic [3:0] wcnt, wcnt_nx;
    logic       mem_start, mem_hold;
    logic       rs_hit, rt_hit;
    logic       load_use, br;

    assign mem_start = (state == RUN) && mem_valid
                       && mem_access && MULTI;
    assign mem_hold  = mem_start
                       || ((state == MEM_WAIT) && (wcnt != 4'd0));
    assign rs_hit    = id_use_rs && (id_rs == ex_rd);
    assign rt_hit    = id_use_rt && (id_rt == ex_rd);
    assign load_use  = id_valid && ex_valid && ex_mem_read
                       && (ex_rd != 5'd0) && (rs_hit || rt_hit);
    assign br        = ex_valid && ex_branch_taken;

    // Strobe decode: memory hold beats branch beats load-use.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        bubble_wb = 1'b0;
        busy      = (state == MEM_WAIT) && !reset;
        if (!reset) begin
            if (mem_hold) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (br) begin
                flush_id  = 1'b1;
                flush_ex  = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_ex  = 1'b1;
            end
        end
    end

    // Next state and wait counter for multi-cycle accesses.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            RUN: begin
                if (mem_start) begin
                    state_nx = MEM_WAIT;
                    wcnt_nx  = WINIT;
                end
            end
            MEM_WAIT: begin
                if (wcnt != 4'd0) wcnt_nx  = wcnt - 4'd1;
                else              state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Saturating debug statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_if && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (br && !mem_hold && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (latency 1, 3, 4)
// checked against an access-timeline reference model.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_valid, ex_mem_read, ex_branch_taken;
    logic       mem_valid, mem_access;

    wire [7:0]  o0, o1, o2;
    wire [15:0] sc0, sc1, fc0, fc1;
    wire [5:0]  sc2n, fc2n;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int LAT [3] = '{1, 3, 4};
    localparam int SMAX[3] = '{65535, 65535, 63};

    int m_st[3];
    int m_sc[3];
    int m_fc[3];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_access(mem_access),
        .stall_if(o0[7]), .stall_id(o0[6]), .stall_ex(o0[5]),
        .stall_mem(o0[4]), .flush_id(o0[3]), .flush_ex(o0[2]),
        .bubble_wb(o0[1]), .busy(o0[0]),
        .stall_count(sc0), .flush_count(fc0)
    );

    pipeline_hazard_ctrl #(.MEM_LATENCY(3), .CNT_W(16)) u3 (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_access(mem_access),
        .stall_if(o1[7]), .stall_id(o1[6]), .stall_ex(o1[5]),
        .stall_mem(o1[4]), .flush_id(o1[3]), .flush_ex(o1[2]),
        .bubble_wb(o1[1]), .busy(o1[0]),
        .stall_count(sc1), .flush_count(fc1)
    );

    pipeline_hazard_ctrl #(.MEM_LATENCY(4), .CNT_W(6)) u4 (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_access(mem_access),
        .stall_if(o2[7]), .stall_id(o2[6]), .stall_ex(o2[5]),
        .stall_mem(o2[4]), .flush_id(o2[3]), .flush_ex(o2[2]),
        .bubble_wb(o2[1]), .busy(o2[0]),
        .stall_count(sc2n), .flush_count(fc2n)
    );

    function automatic logic [7:0] outs(int i);
        case (i)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    function automatic int scnt(int i);
        case (i)
            0:       return int'(sc0);
            1:       return int'(sc1);
            default: return int'(sc2n);
        endcase
    endfunction

    function automatic int fcnt(int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2n);
        endcase
    endfunction

    // Cycle index within the current access, -1 when MEM is idle.
    function automatic int m_idx(int i);
        if (m_st[i] < 0 && mem_valid && mem_access && LAT[i] > 1)
            return 0;
        return m_st[i];
    endfunction

    function automatic logic [7:0] m_out(int i);
        int  s;
        bit  hold, br, lu, bz;
        if (reset) return 8'd0;
        s    = m_idx(i);
        hold = (s >= 0) && (s <= LAT[i] - 2);
        bz   = (m_st[i] >= 1);
        br   = ex_valid && ex_branch_taken;
        lu   = id_valid && ex_valid && ex_mem_read && (ex_rd != 0)
               && ((id_use_rs && id_rs == ex_rd)
                   || (id_use_rt && id_rt == ex_rd));
        if (hold)    return {7'b1111001, bz};
        else if (br) return {7'b0000110, bz};
        else if (lu) return {7'b1100010, bz};
        return {7'b0, bz};
    endfunction

    task automatic tick();
        logic [7:0] e;
        int s;
        for (int i = 0; i < 3; i++) begin
            e = m_out(i);
            if (reset) begin
                m_st[i] = -1;
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                s = m_idx(i);
                if (s < 0 || s == LAT[i] - 1) m_st[i] = -1;
                else                          m_st[i] = s + 1;
                if (e[7] && m_sc[i] < SMAX[i]) m_sc[i]++;
                if (e[3] && m_fc[i] < SMAX[i]) m_fc[i]++;
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0;
        ex_valid = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_valid = 0; mem_access = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        #1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        mem_valid = 1; mem_access = 1;
        ex_valid = 1; ex_branch_taken = 1;
        #1;
        tick();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (outs(i) !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_out[%0d] actual=%b required=0",
                         i, outs(i));
            end
            n_assert++;
            if (scnt(i) != 0 || fcnt(i) != 0) begin
                n_fail++;
                $display("FAIL reset_cnt[%0d] actual=%0d/%0d required=0/0",
                         i, scnt(i), fcnt(i));
            end
        end
        tick();
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid = 1; id_rs = 5; id_use_rs = 1;
        ex_valid = 1; ex_rd = 5; ex_mem_read = 1;
        #1;
        n_assert++;
        if (o0 !== 8'b11000100) begin
            n_fail++;
            $display("FAIL lu_stall actual=%b required=11000100", o0);
        end
        tick();
        ex_mem_read = 0;
        #1;
        n_assert++;
        if (o0 !== 8'd0) begin
            n_fail++;
            $display("FAIL lu_clear actual=%b required=0", o0);
        end
        n_assert++;
        if (sc0 !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_count actual=%0d required=1", sc0);
        end
        tick();
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        id_valid = 1; id_rs = 0; id_use_rs = 1;
        ex_valid = 1; ex_rd = 0; ex_mem_read = 1;
        #1;
        n_assert++;
        if (o0 !== 8'd0) begin
            n_fail++;
            $display("FAIL r0_hazard actual=%b required=0", o0);
        end
        tick();
        id_rs = 3; id_rt = 9; id_use_rt = 0; ex_rd = 9;
        #1;
        n_assert++;
        if (o0 !== 8'd0) begin
            n_fail++;
            $display("FAIL rt_unused actual=%b required=0", o0);
        end
        tick();
    endtask

    task automatic test_mem_latency();
        logic [7:0] exp3 [4];
        exp3 = '{8'b11110010, 8'b11110011, 8'b00000001, 8'b0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            mem_valid  = (c < 3);
            mem_access = (c < 3);
            #1;
            n_assert++;
            if (o1 !== exp3[c]) begin
                n_fail++;
                $display("FAIL lat3_c%0d actual=%b required=%b",
                         c, o1, exp3[c]);
            end
            n_assert++;
            if (o0 !== 8'd0) begin
                n_fail++;
                $display("FAIL lat1_c%0d actual=%b required=0", c, o0);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp3 [3];
        exp3 = '{8'b11110010, 8'b11110011, 8'b00001101};
        do_reset();
        id_valid = 1; id_rt = 7; id_use_rt = 1;
        ex_valid = 1; ex_rd = 7; ex_mem_read = 1;
        ex_branch_taken = 1;
        #1;
        n_assert++;
        if (o0 !== 8'b00001100) begin
            n_fail++;
            $display("FAIL br_lu actual=%b required=00001100", o0);
        end
        tick();
        idle_inputs();
        #1;
        n_assert++;
        if (fc0 !== 16'd1 || sc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL br_lu_cnt actual=%0d/%0d required=1/0",
                     fc0, sc0);
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            mem_valid = 1; mem_access = 1;
            ex_valid = 1; ex_branch_taken = 1;
            #1;
            n_assert++;
            if (o1 !== exp3[c]) begin
                n_fail++;
                $display("FAIL br_wait_c%0d actual=%b required=%b",
                         c, o1, exp3[c]);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_assert++;
        if (fc1 !== 16'd1) begin
            n_fail++;
            $display("FAIL br_wait_cnt actual=%0d required=1", fc1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'b11101110;
        do_reset();
        mem_valid = 1; mem_access = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_assert++;
            if (o2[7] !== pat[7-c]) begin
                n_fail++;
                $display("FAIL b2b_c%0d actual=%b required=%b",
                         c, o2[7], pat[7-c]);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_assert++;
        if (sc2n !== 6'd6) begin
            n_fail++;
            $display("FAIL b2b_count actual=%0d required=6", sc2n);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_valid = 1; mem_access = 1;
        tick();
        #1;
        n_assert++;
        if (o2 !== 8'b11110011) begin
            n_fail++;
            $display("FAIL mid_wait1 actual=%b required=11110011", o2);
        end
        tick();
        reset = 1;
        #1;
        n_assert++;
        if (o2 !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset actual=%b required=0", o2);
        end
        tick();
        reset = 0;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_assert++;
            if (o2 !== 8'd0 || sc2n !== 6'd0 || fc2n !== 6'd0) begin
                n_fail++;
                $display("FAIL post_reset_c%0d actual=%b/%0d/%0d required=0/0/0",
                         c, o2, sc2n, fc2n);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        id_valid = 1; id_rs = 4; id_use_rs = 1;
        ex_valid = 1; ex_rd = 4; ex_mem_read = 1;
        for (int c = 0; c < 69; c++) tick();
        idle_inputs();
        #1;
        n_assert++;
        if (sc2n !== 6'd63) begin
            n_fail++;
            $display("FAIL sat_w6 actual=%0d required=63", sc2n);
        end
        n_assert++;
        if (sc0 !== 16'd69) begin
            n_fail++;
            $display("FAIL sat_w16 actual=%0d required=69", sc0);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset           = ($urandom_range(0, 49) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            ex_valid        = ($urandom_range(0, 3) != 0);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_valid       = 1'($urandom);
            mem_access      = 1'($urandom);
            #1;
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (outs(i) !== m_out(i)) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d] c%0d actual=%b required=%b",
                             i, c, outs(i), m_out(i));
                end
                n_assert++;
                if (scnt(i) != m_sc[i] || fcnt(i) != m_fc[i]) begin
                    n_fail++;
                    $display("FAIL rand_cnt[%0d] c%0d actual=%0d/%0d required=%0d/%0d",
                             i, c, scnt(i), fcnt(i), m_sc[i], m_fc[i]);
                end
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_st[i] = -1;
            m_sc[i] = 0;
            m_fc[i] = 0;
        end
        idle_inputs();
        reset = 1;
        @(negedge clock);
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_mem_latency();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wait();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
